// File: rtl/exposure_timer_if.sv
// Signal bundle between the exposure timer, the exposure buttons and the control FSM.
// The master side drives buttons and phase levels; the slave side returns the exposure time and the pulses.
interface exposure_timer_if #(
    parameter int EXP_W = 5
) ();
    logic             Exp_increase;
    logic             Exp_decrease;
    logic             Expose;
    logic             Readout;
    logic [EXP_W-1:0] Exp_time;
    logic             Ovf5;
    logic             Ovf4;
    logic             Busy;

    modport master (
        output Exp_increase,
        output Exp_decrease,
        output Expose,
        output Readout,
        input  Exp_time,
        input  Ovf5,
        input  Ovf4,
        input  Busy
    );

    modport slave (
        input  Exp_increase,
        input  Exp_decrease,
        input  Expose,
        input  Readout,
        output Exp_time,
        output Ovf5,
        output Ovf4,
        output Busy
    );
endinterface

// File: rtl/exposure_timer.sv
// Exposure/readout timing source: holds the button-adjusted exposure time and produces
// the Ovf5 (end of exposure) and Ovf4 (end of readout phase) pulses for the control FSM.
module exposure_timer #(
    parameter int TICK_DIV    = 4,
    parameter int EXP_MIN     = 2,
    parameter int EXP_MAX     = 30,
    parameter int EXP_W       = 5,
    parameter int READ_CYCLES = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    exposure_timer_if.slave   bus
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W  = EXP_W + TICK_W;
    localparam int READ_W = (READ_CYCLES > 2) ? $clog2(READ_CYCLES) : 1;

    typedef enum logic {E_IDLE, E_RUN} eState_t;
    typedef enum logic {R_IDLE, R_RUN} rState_t;

    eState_t           eState_q, eState_d;
    rState_t           rState_q, rState_d;
    logic [CNT_W-1:0]  eCount_q, eCount_d;
    logic [READ_W-1:0] rCount_q, rCount_d;
    logic [EXP_W-1:0]  expTime_q, expTime_d;
    logic              ovf5_q, ovf5_d;
    logic              ovf4_q, ovf4_d;
    logic              busy_q, busy_d;
    logic              incPrev_q, decPrev_q, exposePrev_q, readoutPrev_q;

    logic              incRise, decRise;
    logic              exposeRise, exposeFall;
    logic              readoutRise, readoutFall;
    logic              timersActive;
    logic [CNT_W-1:0]  expProduct;

    assign incRise     = bus.Exp_increase & ~incPrev_q;
    assign decRise     = bus.Exp_decrease & ~decPrev_q;
    assign exposeRise  = bus.Expose  & ~exposePrev_q;
    assign exposeFall  = ~bus.Expose & exposePrev_q;
    assign readoutRise = bus.Readout  & ~readoutPrev_q;
    assign readoutFall = ~bus.Readout & readoutPrev_q;

    // Wide enough that EXP_MAX*TICK_DIV never truncates; EXP_MIN >= 1 keeps the -1 from wrapping.
    assign expProduct = CNT_W'(expTime_q) * CNT_W'(TICK_DIV) - CNT_W'(1);

    // Buttons are ignored on any edge where a timer is already running, so the
    // loaded exposure cannot be disturbed mid-run.
    assign timersActive = (eState_q == E_RUN) || (rState_q == R_RUN);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            eState_q      <= E_IDLE;
            rState_q      <= R_IDLE;
            eCount_q      <= '0;
            rCount_q      <= '0;
            expTime_q     <= EXP_W'(EXP_MIN);
            ovf5_q        <= 1'b0;
            ovf4_q        <= 1'b0;
            busy_q        <= 1'b0;
            incPrev_q     <= 1'b0;
            decPrev_q     <= 1'b0;
            exposePrev_q  <= 1'b0;
            readoutPrev_q <= 1'b0;
        end else begin
            eState_q      <= eState_d;
            rState_q      <= rState_d;
            eCount_q      <= eCount_d;
            rCount_q      <= rCount_d;
            expTime_q     <= expTime_d;
            ovf5_q        <= ovf5_d;
            ovf4_q        <= ovf4_d;
            busy_q        <= busy_d;
            incPrev_q     <= bus.Exp_increase;
            decPrev_q     <= bus.Exp_decrease;
            exposePrev_q  <= bus.Expose;
            readoutPrev_q <= bus.Readout;
        end
    end

    // An abort on the terminal-count edge wins over the pulse.
    always_comb begin
        eState_d = eState_q;
        eCount_d = eCount_q;
        ovf5_d   = 1'b0;
        case (eState_q)
            E_IDLE: begin
                if (exposeRise) begin
                    eState_d = E_RUN;
                    eCount_d = expProduct;
                end
            end
            E_RUN: begin
                if (exposeFall) begin
                    eState_d = E_IDLE;
                end else if (eCount_q == '0) begin
                    eState_d = E_IDLE;
                    ovf5_d   = 1'b1;
                end else begin
                    eCount_d = eCount_q - CNT_W'(1);
                end
            end
            default: eState_d = E_IDLE;
        endcase
    end

    always_comb begin
        rState_d = rState_q;
        rCount_d = rCount_q;
        ovf4_d   = 1'b0;
        case (rState_q)
            R_IDLE: begin
                if (readoutRise) begin
                    rState_d = R_RUN;
                    rCount_d = READ_W'(READ_CYCLES - 1);
                end
            end
            R_RUN: begin
                if (readoutFall) begin
                    rState_d = R_IDLE;
                end else if (rCount_q == '0) begin
                    rState_d = R_IDLE;
                    ovf4_d   = 1'b1;
                end else begin
                    rCount_d = rCount_q - READ_W'(1);
                end
            end
            default: rState_d = R_IDLE;
        endcase
    end

    // Busy lags a start by one edge but drops on the same edge as the pulse or abort.
    always_comb begin
        busy_d    = ((eState_q == E_RUN) && (eState_d == E_RUN)) ||
                    ((rState_q == R_RUN) && (rState_d == R_RUN));
        expTime_d = expTime_q;
        if (!timersActive) begin
            if (incRise && !decRise && (expTime_q < EXP_W'(EXP_MAX))) begin
                expTime_d = expTime_q + EXP_W'(1);
            end else if (decRise && !incRise && (expTime_q > EXP_W'(EXP_MIN))) begin
                expTime_d = expTime_q - EXP_W'(1);
            end
        end
    end

    assign bus.Exp_time = expTime_q;
    assign bus.Ovf5     = ovf5_q;
    assign bus.Ovf4     = ovf4_q;
    assign bus.Busy     = busy_q;
endmodule

// File: tb/tb_exposure_timer.sv
// Scoreboard bench for exposure_timer: an event-level model predicts when each output
// changes, and a negedge monitor pops and compares those predictions against the DUT.
module tb_exposure_timer;
    localparam int TICK_DIV    = 4;
    localparam int EXP_MIN     = 2;
    localparam int EXP_MAX     = 30;
    localparam int EXP_W       = 5;
    localparam int READ_CYCLES = 4;

    typedef struct {
        int cyc;
        int val;
    } evt_t;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    evt_t expQ[$];
    evt_t busyQ[$];
    evt_t ovf5Q[$];
    evt_t ovf4Q[$];

    exposure_timer_if #(.EXP_W(EXP_W)) bus ();

    exposure_timer #(
        .TICK_DIV(TICK_DIV),
        .EXP_MIN(EXP_MIN),
        .EXP_MAX(EXP_MAX),
        .EXP_W(EXP_W),
        .READ_CYCLES(READ_CYCLES)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic inc, input logic dec, input logic expo,
                                 input logic rd, input logic rst, input int n);
        bus.Exp_increase = inc;
        bus.Exp_decrease = dec;
        bus.Expose       = expo;
        bus.Readout      = rd;
        Reset            = rst;
        repeat (n) @(negedge Clk);
    endtask

    task automatic pressButton(input bit up, input int times);
        for (int i = 0; i < times; i++) begin
            applyStimulus(up, !up, 1'b0, 1'b0, 1'b0, 1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        end
    endtask

    // Reference model: exposures and readout phases are tracked as deadlines
    // (start edge + duration); a phase either reaches its deadline or is cancelled.
    initial begin
        int  expT;
        bit  mBusy, newBusy;
        bit  pInc, pDec, pExp, pRd;
        bit  ePend, rPend;
        int  eStart, eDead, rStart, rDead;
        bit  incR, decR, eRise, eFall, rRise, rFall, locked;
        int  nt;
        expT = EXP_MIN; mBusy = 0;
        pInc = 0; pDec = 0; pExp = 0; pRd = 0;
        ePend = 0; rPend = 0; eStart = 0; eDead = 0; rStart = 0; rDead = 0;
        forever begin
            @(posedge Clk);
            cyc++;
            if (Reset) begin
                pInc = 0; pDec = 0; pExp = 0; pRd = 0;
                ePend = 0; rPend = 0;
                if (expT != EXP_MIN) expQ.push_back('{cyc, EXP_MIN});
                expT    = EXP_MIN;
                newBusy = 0;
            end else begin
                incR  = bus.Exp_increase && !pInc;
                decR  = bus.Exp_decrease && !pDec;
                eRise = bus.Expose && !pExp;
                eFall = !bus.Expose && pExp;
                rRise = bus.Readout && !pRd;
                rFall = !bus.Readout && pRd;
                locked = ePend || rPend;
                if (ePend) begin
                    if (eFall) ePend = 0;
                    else if (cyc == eDead) begin
                        ovf5Q.push_back('{cyc, 1});
                        ePend = 0;
                    end
                end else if (eRise) begin
                    ePend = 1; eStart = cyc; eDead = cyc + expT * TICK_DIV;
                end
                if (rPend) begin
                    if (rFall) rPend = 0;
                    else if (cyc == rDead) begin
                        ovf4Q.push_back('{cyc, 1});
                        rPend = 0;
                    end
                end else if (rRise) begin
                    rPend = 1; rStart = cyc; rDead = cyc + READ_CYCLES;
                end
                if (!locked && (incR != decR)) begin
                    nt = incR ? expT + 1 : expT - 1;
                    if (nt > EXP_MAX) nt = EXP_MAX;
                    if (nt < EXP_MIN) nt = EXP_MIN;
                    if (nt != expT) expQ.push_back('{cyc, nt});
                    expT = nt;
                end
                newBusy = (ePend && eStart < cyc) || (rPend && rStart < cyc);
                pInc = bus.Exp_increase; pDec = bus.Exp_decrease;
                pExp = bus.Expose;       pRd  = bus.Readout;
            end
            if (newBusy != mBusy) busyQ.push_back('{cyc, int'(newBusy)});
            mBusy = newBusy;
        end
    end

    // Monitor: every observed output change or pulse consumes one predicted event.
    initial begin
        logic [EXP_W-1:0] lastExp;
        logic             lastBusy;
        evt_t             ev;
        lastExp  = EXP_W'(EXP_MIN);
        lastBusy = 1'b0;
        forever begin
            @(negedge Clk);
            if (bus.Exp_time !== lastExp) begin
                if (expQ.size() == 0) checkOutput("exp_time_unexpected", int'(bus.Exp_time), int'(lastExp));
                else begin
                    ev = expQ.pop_front();
                    checkOutput("exp_time_edge", cyc, ev.cyc);
                    checkOutput("exp_time_value", int'(bus.Exp_time), ev.val);
                end
                lastExp = bus.Exp_time;
            end
            if (bus.Busy !== lastBusy) begin
                if (busyQ.size() == 0) checkOutput("busy_unexpected", int'(bus.Busy), int'(lastBusy));
                else begin
                    ev = busyQ.pop_front();
                    checkOutput("busy_edge", cyc, ev.cyc);
                    checkOutput("busy_value", int'(bus.Busy), ev.val);
                end
                lastBusy = bus.Busy;
            end
            if (bus.Ovf5 !== 1'b0) begin
                if (ovf5Q.size() == 0) checkOutput("ovf5_unexpected", 1, 0);
                else begin
                    ev = ovf5Q.pop_front();
                    checkOutput("ovf5_edge", cyc, ev.cyc);
                end
            end
            if (bus.Ovf4 !== 1'b0) begin
                if (ovf4Q.size() == 0) checkOutput("ovf4_unexpected", 1, 0);
                else begin
                    ev = ovf4Q.pop_front();
                    checkOutput("ovf4_edge", cyc, ev.cyc);
                end
            end
        end
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        checkOutput("reset_exp_time", int'(bus.Exp_time), EXP_MIN);
        checkOutput("reset_busy", int'(bus.Busy), 0);
        checkOutput("reset_ovf5", int'(bus.Ovf5), 0);
        checkOutput("reset_ovf4", int'(bus.Ovf4), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        pressButton(1'b1, 3);
        pressButton(1'b1, 40);
        pressButton(1'b0, 40);
        pressButton(1'b1, 3);

        // Full exposure at 5 units, Expose held past Ovf5
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 25);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        // Aborted exposure, then a button press must be accepted
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        pressButton(1'b1, 1);
        pressButton(1'b0, 1);

        // Readout overlapping an exposure, with a blocked increase
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 15);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        // Reset mid-exposure, then simultaneous inc+dec while idle
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 25);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        // Button held through reset counts as a rise afterwards
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        begin
            logic rInc, rDec, rExp, rRd, rRst;
            rExp = 1'b0; rRd = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                rInc = ($urandom_range(0, 3) == 0);
                rDec = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 29) == 0) rExp = !rExp;
                if ($urandom_range(0, 7) == 0)  rRd  = !rRd;
                rRst = ($urandom_range(0, 249) == 0);
                applyStimulus(rInc, rDec, rExp, rRd, rRst, 1);
            end
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 150);
        checkOutput("exp_queue_drained", expQ.size(), 0);
        checkOutput("busy_queue_drained", busyQ.size(), 0);
        checkOutput("ovf5_queue_drained", ovf5Q.size(), 0);
        checkOutput("ovf4_queue_drained", ovf4Q.size(), 0);
        $display("test done: total=%0d bad=%0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exposure_timer.md
# exposure_timer

Timing source for the camera exposure/readout sequencer. Holds the user-adjustable exposure time, stepped by the Exp_increase/Exp_decrease buttons. Produces the two overflow pulses the control FSM waits on: Ovf5 ends the exposure phase and Ovf4 ends each readout phase. It sits directly upstream of the control FSM. It takes the FSM's Expose and readout-phase outputs as start requests and returns Ovf5/Ovf4.

## Interface
- TICK_DIV, 4: clock cycles per exposure unit (1 unit = 1 ms in silicon; 4 for simulation).
- EXP_MIN, 2: minimum exposure, units.
- EXP_MAX, 30: maximum exposure, units.
- EXP_W, 5: width of exposure register.
- READ_CYCLES, 4: length of one readout phase, clock cycles.
- Clk  in  1  single system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Exp_increase  in  1  button level; each rising edge requests +1 unit.
- Exp_decrease  in  1  button level; each rising edge requests −1 unit.
- Expose  in  1  from FSM; level high during exposure phase.
- Readout  in  1  from FSM; high during any readout phase (NRE_1/ADC/NRE_2 OR-ed at top level).
- Exp_time  out  EXP_W  current exposure setting, units.
- Ovf5  out  1  one-cycle pulse at end of exposure.
- Ovf4  out  1  one-cycle pulse at end of readout phase.
- Busy  out  1  high while either timer runs.

## Operation
- Reset values: Exp_time = EXP_MIN, Ovf5 = 0, Ovf4 = 0, Busy = 0, both counters idle. Edge-detect registers load 0, so a button held through reset counts as a rising edge on the first post-reset cycle.
- Edge detection: one register per input (Exp_increase, Exp_decrease, Expose, Readout). "Rise" = sampled 1 this edge and 0 the previous edge.
- Exposure adjust, evaluated only when Busy = 0:
  - inc rise alone: Exp_time + 1, saturating at EXP_MAX.
  - dec rise alone: Exp_time − 1, saturating at EXP_MIN.
  - inc and dec rise in the same cycle: no change.
  - Button rises while Busy = 1 are discarded, not queued.
- Exposure timer states: E_IDLE, E_RUN.
  - E_IDLE → E_RUN on Expose rise. Load down-counter with Exp_time*TICK_DIV − 1. The product width is EXP_W + clog2(TICK_DIV) bits, with no truncation.
  - In E_RUN the counter decrements each cycle.
  - At 0: pulse Ovf5 for one cycle, return to E_IDLE.
  - Expose falling while in E_RUN: abort to E_IDLE with no Ovf5.
- Readout timer states: R_IDLE, R_RUN.
  - R_IDLE → R_RUN on Readout rise. Load READ_CYCLES − 1.
  - Decrement each cycle; at 0 pulse Ovf4 for one cycle and return to R_IDLE.
  - Readout falling in R_RUN: abort with no Ovf4.
  - Readout still high after Ovf4: no restart; a new rise is required for each phase.
- The two timers are independent. Both may run at once; both pulses may coincide.
- Busy = (E_RUN or R_RUN), registered.
- Exp_time is sampled at the Expose rise. It cannot change during E_RUN, because adjustments are blocked while busy.

## Timing
- Button rise first sampled at edge N: Exp_time updated at edge N+1.
- Expose first sampled high at edge N: Ovf5 high for the cycle after edge N + Exp_time*TICK_DIV, and for that cycle only.
- Readout first sampled high at edge N: Ovf4 high after edge N + READ_CYCLES, for one cycle.
- Busy rises at edge N+1 after a start and falls on the same edge that asserts the overflow pulse.
- Reset asserted mid-run: counters idle, pulses 0, and Exp_time = EXP_MIN at the next edge. No pulse is emitted after reset.
- A start rise on the same edge as Reset is ignored.

## Test plan
- Reset, then 3 Exp_increase pulses: Exp_time 2→5, one step per pulse, each one edge after the rise.
- 40 increase pulses then 40 decrease pulses: saturates at 30, then at 2. No wrap to 0 or 31.
- Exp_time = 5, TICK_DIV = 4, Expose rises at edge 10: Ovf5 high exactly one cycle after edge 30; Busy high across edges 11–30.
- Expose drops at cycle 8 of a 20-cycle exposure: no Ovf5. Busy falls the next edge. A following button press is accepted.
- Readout rises while exposure is running: Ovf4 after 4 edges, Ovf5 unaffected. An Exp_increase during this window leaves Exp_time unchanged.
- Reset pulsed mid-exposure, and inc+dec risen together when idle: no Ovf5, Exp_time = 2, and the simultaneous press changes nothing.
